// File: rtl/gpio_loader_pkg.sv
// Shared definitions for the GPIO serial configuration loader and the control-block chain.
package gpio_loader_pkg;

  localparam int unsigned GPIO_NUM_IO        = 19;
  localparam int unsigned GPIO_PAD_CTRL_BITS = 10;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    CLK,
    GAP,
    LOAD,
    END
  } loader_state_t;

endpackage

// File: rtl/gpio_serial_loader.sv
// Shifts NUM_IO configuration words MSB-first, farthest block first, into the GPIO chain, then strobes load.
// Optional readback of the chain tail is enabled by defining GPIO_LOADER_READBACK_EN.
module gpio_serial_loader
  import gpio_loader_pkg::*;
#(
  parameter int unsigned NUM_IO        = GPIO_NUM_IO,
  parameter int unsigned PAD_CTRL_BITS = GPIO_PAD_CTRL_BITS,
  parameter int unsigned IDX_W         = $clog2(NUM_IO)
) (
  input  logic                     serial_clock,
  input  logic                     resetn,
  input  logic                     xfer_start,
  output logic [IDX_W-1:0]         cfg_idx,
  input  logic [PAD_CTRL_BITS-1:0] cfg_data,
  output logic                     ser_clk,
  output logic                     ser_data,
  output logic                     ser_load,
  output logic                     busy,
  output logic                     done
`ifdef GPIO_LOADER_READBACK_EN
  ,
  input  logic                     ser_data_ret,
  output logic [PAD_CTRL_BITS-1:0] rb_data
`endif
);

  localparam int unsigned BIT_W = $clog2(PAD_CTRL_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_IO - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAD_CTRL_BITS - 1);

  loader_state_t    state;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_nxt;
  logic [BIT_W-1:0] bit_q;
  logic [BIT_W-1:0] bit_nxt;
  logic             to_data;

  // Next counter values and whether the coming edge enters DATA.
  always_comb begin
    idx_nxt = idx_q;
    bit_nxt = bit_q;
    to_data = 1'b0;
    case (state)
      IDLE: begin
        if (xfer_start) begin
          idx_nxt = IDX_LAST;
          bit_nxt = BIT_LAST;
          to_data = 1'b1;
        end
      end
      CLK: begin
        if (bit_q != '0) begin
          bit_nxt = bit_q - 1'b1;
          to_data = 1'b1;
        end else if (idx_q != '0) begin
          idx_nxt = idx_q - 1'b1;
          bit_nxt = BIT_LAST;
          to_data = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // The word port is addressed with the look-ahead index so the bit captured on the
  // edge entering DATA comes from the word it belongs to, including the first bit
  // after start and the first bit of each new word.
  assign cfg_idx = resetn ? idx_nxt : '0;

  always_ff @(posedge serial_clock or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      idx_q    <= '0;
      bit_q    <= '0;
      ser_clk  <= 1'b0;
      ser_data <= 1'b0;
      ser_load <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      idx_q <= idx_nxt;
      bit_q <= bit_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          ser_clk  <= 1'b0;
          ser_load <= 1'b0;
          ser_data <= 1'b0;
          if (to_data) begin
            ser_data <= cfg_data[bit_nxt];
            busy     <= 1'b1;
            state    <= DATA;
          end
        end
        DATA: begin
          ser_clk <= 1'b1;
          state   <= CLK;
        end
        CLK: begin
          ser_clk <= 1'b0;
          if (to_data) begin
            ser_data <= cfg_data[bit_nxt];
            state    <= DATA;
          end else begin
            ser_data <= 1'b0;
            state    <= GAP;
          end
        end
        GAP: begin
          ser_load <= 1'b1;
          state    <= LOAD;
        end
        LOAD: begin
          ser_load <= 1'b0;
          done     <= 1'b1;
          state    <= END;
        end
        END: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GPIO_LOADER_READBACK_EN
  localparam int unsigned RB_W = $clog2(PAD_CTRL_BITS + 1);

  logic [RB_W-1:0] rb_cnt;

  // The first word's worth of tail bits is the farthest block's old contents.
  always_ff @(posedge serial_clock or negedge resetn) begin
    if (!resetn) begin
      rb_cnt  <= '0;
      rb_data <= '0;
    end else if (state == IDLE && xfer_start) begin
      rb_cnt <= '0;
    end else if (state == DATA && rb_cnt < RB_W'(PAD_CTRL_BITS)) begin
      rb_data <= {rb_data[PAD_CTRL_BITS-2:0], ser_data_ret};
      rb_cnt  <= rb_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Self-checking bench for gpio_serial_loader with a two-block chain model (optional readback under GPIO_LOADER_READBACK_EN).
module tb_gpio_serial_loader;

  localparam int NIO = 2;
  localparam int PB  = 10;
  localparam int N   = NIO * PB;

  logic          serial_clock = 1'b0;
  logic          resetn       = 1'b0;
  logic          xfer_start   = 1'b0;
  logic [0:0]    cfg_idx;
  logic [PB-1:0] cfg_data;
  logic          ser_clk, ser_data, ser_load, busy, done;
  logic [PB-1:0] words [NIO];
  logic [PB-1:0] blk0, blk1;

  assign cfg_data = words[cfg_idx];

`ifdef GPIO_LOADER_READBACK_EN
  logic          ser_data_ret;
  logic [PB-1:0] rb_data;
  logic [PB-1:0] rb_at_done;
  assign ser_data_ret = blk1[PB-1];
`endif

  gpio_serial_loader #(
    .NUM_IO(NIO),
    .PAD_CTRL_BITS(PB)
  ) dut (
    .serial_clock(serial_clock),
    .resetn(resetn),
    .xfer_start(xfer_start),
    .cfg_idx(cfg_idx),
    .cfg_data(cfg_data),
    .ser_clk(ser_clk),
    .ser_data(ser_data),
    .ser_load(ser_load),
    .busy(busy),
    .done(done)
`ifdef GPIO_LOADER_READBACK_EN
    ,
    .ser_data_ret(ser_data_ret),
    .rb_data(rb_data)
`endif
  );

  always #5 serial_clock = ~serial_clock;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick;
    @(posedge serial_clock);
    #2;
  endtask

  task automatic pulse_start;
    xfer_start = 1'b1;
    tick();
    xfer_start = 1'b0;
  endtask

  // Model: k = cycle number since the accepted start (0 = idle), outputs follow from k alone.
  logic exp_stream[$];
  int   k;
  bit   chk_en = 1'b0;

  always @(posedge serial_clock or negedge resetn) begin
    if (!resetn) k <= 0;
    else if (k == 0) k <= xfer_start ? 1 : 0;
    else if (k == 2*N + 3) k <= 0;
    else k <= k + 1;
  end

  function automatic logic [4:0] expect_out(input int kk);
    if (kk == 0) return 5'b00000;
    if (kk <= 2*N) return {(kk % 2 == 0), exp_stream[(kk-1)/2], 1'b0, 1'b1, 1'b0};
    if (kk == 2*N + 1) return 5'b00010;
    if (kk == 2*N + 2) return 5'b00110;
    return 5'b00011;
  endfunction

  always @(negedge serial_clock)
    if (chk_en) check("cycle", 32'({ser_clk, ser_data, ser_load, busy, done}), 32'(expect_out(k)));

  // Observations used by the literal checks.
  int          clk_edges = 0;
  logic [19:0] cap = '0;
  int          load_cnt = 0, done_cnt = 0, load_k = -1, done_k = -1;

  always @(posedge ser_clk) begin
    clk_edges++;
    cap = {cap[18:0], ser_data};
  end

  always @(posedge ser_clk or negedge resetn) begin
    if (!resetn) begin
      blk0 <= '0;
      blk1 <= 10'h2C3;
    end else begin
      blk0 <= {blk0[PB-2:0], ser_data};
      blk1 <= {blk1[PB-2:0], blk0[PB-1]};
    end
  end

  always @(negedge serial_clock) begin
    if (ser_load === 1'b1) begin
      load_cnt++;
      load_k = k;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_k = k;
`ifdef GPIO_LOADER_READBACK_EN
      rb_at_done = rb_data;
`endif
    end
  end

  initial begin
    int d0, l0, e0, w;
    words[1] = 10'h3A5;
    words[0] = 10'h0F0;
    for (int i = NIO - 1; i >= 0; i--)
      for (int b = PB - 1; b >= 0; b--)
        exp_stream.push_back(words[i][b]);
    @(posedge serial_clock);
    #2;
    chk_en = 1'b1;

    // Held reset with start asserted.
    xfer_start = 1'b1;
    repeat (20) tick();
    check("reset_outputs", 32'({cfg_idx, ser_clk, ser_data, ser_load, busy, done}), 32'd0);
    check("reset_no_ser_clk", 32'(clk_edges), 32'd0);
    xfer_start = 1'b0;
    resetn = 1'b1;
    repeat (3) tick();

    // Single transfer.
    e0 = clk_edges;
    d0 = done_cnt;
    pulse_start();
    w = 0;
    while (done_cnt == d0 && w < 200) begin
      tick();
      w++;
    end
    check("done_seen", 32'(done_cnt - d0), 32'd1);
    check("ser_clk_edges", 32'(clk_edges - e0), 32'd20);
    check("stream", 32'(cap), 32'(20'b1110100101_0011110000));
    check("load_cycle", 32'(load_k), 32'd42);
    check("done_cycle", 32'(done_k), 32'd43);
    check("block1", 32'(blk1), 32'h3A5);
    check("block0", 32'(blk0), 32'h0F0);
`ifdef GPIO_LOADER_READBACK_EN
    check("readback", 32'(rb_at_done), 32'h2C3);
`endif
    repeat (4) tick();

    // Starts during busy are dropped.
    d0 = done_cnt;
    l0 = load_cnt;
    pulse_start();
    repeat (3) tick();
    pulse_start();
    repeat (24) tick();
    pulse_start();
    repeat (30) tick();
    check("busy_start_dones", 32'(done_cnt - d0), 32'd1);
    check("busy_start_loads", 32'(load_cnt - l0), 32'd1);

    // Held start re-triggers right after END.
    d0 = done_cnt;
    xfer_start = 1'b1;
    repeat (2*N + 5) tick();
    xfer_start = 1'b0;
    repeat (60) tick();
    check("held_start_dones", 32'(done_cnt - d0), 32'd2);

    // Reset in the middle of shifting.
    d0 = done_cnt;
    l0 = load_cnt;
    pulse_start();
    repeat (14) tick();
    check("mid_busy_before", 32'(busy), 32'd1);
    resetn = 1'b0;
    #1;
    check("mid_reset_outputs", 32'({ser_clk, ser_data, ser_load, busy, done}), 32'd0);
    repeat (3) tick();
    resetn = 1'b1;
    repeat (60) tick();
    check("mid_reset_no_load", 32'(load_cnt - l0), 32'd0);
    check("mid_reset_no_done", 32'(done_cnt - d0), 32'd0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
